// File: rtl/vote_pkg.sv
// Shared types and constants for the vote session controller and its window timer.
package vote_pkg;

    localparam int DEF_SCORE_W = 8;

    localparam int W_NP      = 1;
    localparam int W_VIP     = 4;
    localparam int W_VVIP    = 16;
    localparam int MAX_SCORE = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_OPEN,
        ST_SETTLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vote_window_timer.sv
// Voting-window down-counter: loads the window length, counts down to 1, clears to 0 when the window closes.
module vote_window_timer #(
    parameter int CNT_W         = 8,
    parameter int WINDOW_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] remaining_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: always_comb assigns a default first so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(WINDOW_CYCLES);
        end else if (dec_i && cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign remaining_o = cnt_q;
    assign last_o      = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session FSM: clears the tally, runs a fixed window, decides pass/fail and holds the verdict.
// Optional macro VOTE_MONOTONIC_CHECK_EN adds a sticky mono_err flag for a falling score.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int WINDOW_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int SCORE_W       = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [SCORE_W-1:0] threshold,
    input  logic [SCORE_W-1:0] result,
    output logic               tally_clr,
    output logic               window_open,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SCORE_W-1:0] final_score,
    output logic [CNT_W-1:0]   remaining
`ifdef VOTE_MONOTONIC_CHECK_EN
    ,
    output logic               mono_err
`endif
);

    state_e             state_q;
    logic [SCORE_W-1:0] thr_q;
    logic               tally_clr_q;
    logic               window_open_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [SCORE_W-1:0] final_score_q;

    logic reached;
    logic last;
    logic tmr_clr;
    logic tmr_load;
    logic tmr_dec;

    assign reached  = (result >= thr_q);
    assign tmr_clr  = abort || (state_q == ST_OPEN && (reached || last));
    assign tmr_load = (state_q == ST_CLEAR);
    assign tmr_dec  = (state_q == ST_OPEN);

    vote_window_timer #(
        .CNT_W         (CNT_W),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (tmr_load),
        .clr_i       (tmr_clr),
        .dec_i       (tmr_dec),
        .remaining_o (remaining),
        .last_o      (last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            thr_q         <= '0;
            tally_clr_q   <= 1'b0;
            window_open_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            final_score_q <= '0;
        end else begin
            tally_clr_q <= 1'b0;
            if (abort) begin
                state_q       <= ST_IDLE;
                window_open_q <= 1'b0;
                busy_q        <= 1'b0;
                done_q        <= 1'b0;
                pass_q        <= 1'b0;
                final_score_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            thr_q       <= threshold;
                            state_q     <= ST_CLEAR;
                            tally_clr_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        state_q       <= ST_OPEN;
                        window_open_q <= 1'b1;
                    end
                    ST_OPEN: begin
                        // Early decision and last-cycle expiry share one exit.
                        if (reached || last) begin
                            state_q       <= ST_SETTLE;
                            window_open_q <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        final_score_q <= result;
                        pass_q        <= reached;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (start) begin
                            thr_q         <= threshold;
                            state_q       <= ST_CLEAR;
                            tally_clr_q   <= 1'b1;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            pass_q        <= 1'b0;
                            final_score_q <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tally_clr   = tally_clr_q;
    assign window_open = window_open_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign final_score = final_score_q;

`ifdef VOTE_MONOTONIC_CHECK_EN
    logic [SCORE_W-1:0] prev_score_q;
    logic               prev_vld_q;
    logic               mono_err_q;

    // The CLEAR-cycle score is pre-clear, so the first OPEN cycle has no valid predecessor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_score_q <= '0;
            prev_vld_q   <= 1'b0;
            mono_err_q   <= 1'b0;
        end else begin
            prev_score_q <= result;
            prev_vld_q   <= (state_q == ST_OPEN);
            if (state_q == ST_CLEAR) begin
                mono_err_q <= 1'b0;
            end else if ((state_q == ST_OPEN || state_q == ST_SETTLE) &&
                         prev_vld_q && (result < prev_score_q)) begin
                mono_err_q <= 1'b1;
            end
        end
    end

    assign mono_err = mono_err_q;
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: vector table plus directed multi-cycle sequences.
module tb_vote_session_ctrl;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] threshold = '0;
    logic [7:0] result = '0;
    logic       tally_clr, window_open, busy, done, pass;
    logic [7:0] final_score;
    logic [7:0] remaining;
`ifdef VOTE_MONOTONIC_CHECK_EN
    logic       mono_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vote_session_ctrl #(
        .WINDOW_CYCLES (WIN),
        .CNT_W         (8),
        .SCORE_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .threshold   (threshold),
        .result      (result),
        .tally_clr   (tally_clr),
        .window_open (window_open),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .final_score (final_score),
        .remaining   (remaining)
`ifdef VOTE_MONOTONIC_CHECK_EN
        ,
        .mono_err    (mono_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tclr;
        logic       wo;
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] fs;
        logic [7:0] rem;
    } out_t;

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] thr;
        logic [7:0] res;
        out_t       exp;
    } vec_t;

    function automatic out_t mk(input logic t, input logic w, input logic b, input logic d,
                                input logic p, input int fs, input int rem);
        out_t r;
        r.tclr = t;
        r.wo   = w;
        r.busy = b;
        r.done = d;
        r.pass = p;
        r.fs   = 8'(fs);
        r.rem  = 8'(rem);
        return r;
    endfunction

    function automatic vec_t v(input logic s, input logic a, input int thr, input int res, input out_t e);
        vec_t r;
        r.start = s;
        r.abort = a;
        r.thr   = 8'(thr);
        r.res   = 8'(res);
        r.exp   = e;
        return r;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t got;
        got = mk(tally_clr, window_open, busy, done, pass, int'(final_score), int'(remaining));
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got tclr=%0b wo=%0b busy=%0b done=%0b pass=%0b fs=%0d rem=%0d, expected tclr=%0b wo=%0b busy=%0b done=%0b pass=%0b fs=%0d rem=%0d",
                     name, got.tclr, got.wo, got.busy, got.done, got.pass, got.fs, got.rem,
                     exp.tclr, exp.wo, exp.busy, exp.done, exp.pass, exp.fs, exp.rem);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rem(input string name, input int target);
        int guard = 0;
        while (int'(remaining) != target && guard < 40) begin
            step();
            guard++;
        end
        check_val(name, int'(remaining), target);
    endtask

    // Steps through OPEN with a constant score; returns the number of OPEN cycles seen.
    task automatic run_window(input int res, output int open_cnt);
        int guard = 0;
        open_cnt = window_open ? 1 : 0;
        while (window_open && guard < 40) begin
            result = 8'(res);
            step();
            guard++;
            if (window_open) open_cnt++;
        end
    endtask

    out_t o_idle, o_clr, o_open16, o_settle;
    vec_t vecs[18];

    initial begin
        int cnt;
        int last_rem;
        int guard;

        o_idle   = mk(0, 0, 0, 0, 0, 0, 0);
        o_clr    = mk(1, 0, 1, 0, 0, 0, 0);
        o_open16 = mk(0, 1, 1, 0, 0, 0, WIN);
        o_settle = mk(0, 0, 1, 0, 0, 0, 0);

        vecs[0]  = v(1, 0, 0,  77, o_clr);
        vecs[1]  = v(0, 0, 0,  77, o_open16);
        vecs[2]  = v(0, 0, 0,   0, o_settle);
        vecs[3]  = v(0, 0, 0,   0, mk(0, 0, 0, 1, 1, 0, 0));
        vecs[4]  = v(0, 0, 0,   0, mk(0, 0, 0, 1, 1, 0, 0));
        vecs[5]  = v(1, 0, 90,  0, o_clr);
        vecs[6]  = v(0, 0, 0,   0, o_open16);
        vecs[7]  = v(1, 1, 0,   0, o_idle);
        vecs[8]  = v(1, 1, 0,   0, o_idle);
        vecs[9]  = v(1, 0, 5,   3, o_clr);
        vecs[10] = v(0, 1, 5,   3, o_idle);
        vecs[11] = v(1, 0, 5,   0, o_clr);
        vecs[12] = v(1, 0, 5,   0, o_open16);
        vecs[13] = v(1, 0, 5,   5, o_settle);
        vecs[14] = v(1, 0, 5,   6, mk(0, 0, 0, 1, 1, 6, 0));
        vecs[15] = v(0, 0, 5,   6, mk(0, 0, 0, 1, 1, 6, 0));
        vecs[16] = v(1, 0, 7,   6, o_clr);
        vecs[17] = v(0, 1, 7,   6, o_idle);

        #12;
        check_out("reset_state", o_idle);
`ifdef VOTE_MONOTONIC_CHECK_EN
        check_val("reset_mono", int'(mono_err), 0);
`endif
        reset = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            start     = vecs[i].start;
            abort     = vecs[i].abort;
            threshold = vecs[i].thr;
            result    = vecs[i].res;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        start = 1'b0;
        abort = 1'b0;

        // Async reset mid-window, then no restart without start.
        start = 1'b1; threshold = 8'd50; result = 8'd0;
        step();
        check_out("A_clear", o_clr);
        start = 1'b0;
        wait_rem("A_rem9", 9);
        #2 reset = 1'b0;
        #1 check_out("A_async_reset", o_idle);
        step();
        reset = 1'b1;
        step();
        step();
        check_out("A_no_autostart", o_idle);
        start = 1'b1;
        step();
        check_out("A_restart", o_clr);

        // Full window, score below threshold 50.
        start = 1'b0;
        step();
        check_out("B_open", o_open16);
        cnt = 1;
        guard = 0;
        while (window_open && guard < 40) begin
            result = (cnt < 2) ? 8'd0 : (cnt < 3) ? 8'd20 : (cnt < 4) ? 8'd36 : 8'd48;
            step();
            guard++;
            if (window_open) cnt++;
        end
        check_val("B_open_cycles", cnt, WIN);
        check_out("B_settle", o_settle);
        step();
        check_out("B_done", mk(0, 0, 0, 1, 0, 48, 0));

        // Early exit at threshold 20; threshold input changes mid-session are ignored.
        start = 1'b1; threshold = 8'd20;
        step();
        check_out("C_clear", o_clr);
        start = 1'b0; result = 8'd0; threshold = 8'd0;
        step();
        check_out("C_open", o_open16);
        cnt = 1;
        last_rem = 0;
        guard = 0;
        while (window_open && guard < 40) begin
            last_rem = int'(remaining);
            result = (remaining <= 8'd12) ? 8'd20 : 8'd0;
            step();
            guard++;
            if (window_open) cnt++;
        end
        check_val("C_exit_rem", last_rem, 12);
        check_val("C_open_cycles", cnt, 5);
        check_out("C_settle", o_settle);
        step();
        check_out("C_done", mk(0, 0, 0, 1, 1, 20, 0));

        // Vote in the last OPEN cycle is counted by SETTLE.
        start = 1'b1; threshold = 8'd16;
        step();
        start = 1'b0; result = 8'd15;
        step();
        run_window(15, cnt);
        check_val("D_open_cycles", cnt, WIN);
        check_out("D_settle", o_settle);
        result = 8'd16;
        step();
        check_out("D_done", mk(0, 0, 0, 1, 1, 16, 0));

        // Abort with start held, restart, then unreachable threshold runs the full window.
        start = 1'b1; threshold = 8'd90;
        step();
        start = 1'b0; result = 8'd80;
        step();
        wait_rem("E_rem5", 5);
        abort = 1'b1; start = 1'b1;
        step();
        check_out("E_abort", o_idle);
        abort = 1'b0;
        step();
        check_out("E_restart", o_clr);
        start = 1'b0;
        step();
        check_out("E_open", o_open16);
        run_window(80, cnt);
        check_val("E_open_cycles", cnt, WIN);
        step();
        check_out("E_done", mk(0, 0, 0, 1, 0, 80, 0));

`ifdef VOTE_MONOTONIC_CHECK_EN
        start = 1'b1;
        step();
        start = 1'b0; result = 8'd0;
        step();
        check_val("F_no_false_err", int'(mono_err), 0);
        result = 8'd30;
        step();
        result = 8'd29;
        step();
        check_val("F_mono_set", int'(mono_err), 1);
        run_window(29, cnt);
        step();
        check_val("F_done", int'(done), 1);
        check_val("F_mono_held", int'(mono_err), 1);
        start = 1'b1;
        step();
        start = 1'b0; result = 8'd0;
        step();
        check_val("F_mono_cleared", int'(mono_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
